// File: rtl/down_count_tracker.sv
// Watches a 4-bit down counter, counts wraps (0 -> F) and queues WRAP (and optional JUMP) events in a small FIFO.
// Optional feature: define DCT_JUMP_EVENT_EN to also push JUMP events (type 2'b10).
module down_count_tracker #(
  parameter int DEPTH  = 4,  // legal values: 2, 4, 8
  parameter int WRAP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          cnt_in,
  input  logic                clr,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [WRAP_W+5:0]   ev_data,
  output logic [WRAP_W-1:0]   wrap_cnt,
  output logic                ovf,
  output logic                dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = WRAP_W + 6;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [1:0]  TYPE_WRAP = 2'b01;
  localparam logic [1:0]  TYPE_JUMP = 2'b10;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        prev_q, prev_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              ovf_q, ovf_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       count_q, count_d;

  logic              is_wrap;
  logic              push;
  logic [1:0]        ev_type;
  logic [EW-1:0]     ev_word;
  logic              pop;
  logic              full;
  logic              push_acc;
  logic              drop;

  // Handshake: the head entry is presented while ev_valid=1 and is consumed on a
  // rising edge with ev_valid && ev_ready; ev_ready is ignored while empty.
  assign ev_valid  = (count_q != '0);
  assign ev_data   = ev_valid ? mem_q[rd_ptr_q] : '0;
  assign wrap_cnt  = wrap_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    is_wrap = 1'b0;
    push    = 1'b0;
    ev_type = TYPE_WRAP;
    case (state_q)
      SYNC: begin
        prev_d  = cnt_in;
        state_d = TRACK;
      end
      TRACK: begin
        prev_d = cnt_in;
        if (cnt_in == prev_q) begin
          push = 1'b0;
        end else if ((prev_q != 4'h0) && (cnt_in == prev_q - 4'd1)) begin
          push = 1'b0;
        end else if ((prev_q == 4'h0) && (cnt_in == 4'hF)) begin
          is_wrap = 1'b1;
          push    = 1'b1;
          ev_type = TYPE_WRAP;
        end else begin
`ifdef DCT_JUMP_EVENT_EN
          push    = 1'b1;
          ev_type = TYPE_JUMP;
`else
          push    = 1'b0;
`endif
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // clr wins over a same-cycle wrap, and the pushed event carries the cleared value.
  always_comb begin
    wrap_d = wrap_q;
    if (clr) begin
      wrap_d = '0;
    end else if (is_wrap) begin
      wrap_d = wrap_q + WRAP_W'(1);
    end
  end

  assign ev_word  = {ev_type, wrap_d, cnt_in};
  assign pop      = ev_valid && ev_ready;
  assign full     = (count_q == FULL_CNT);
  assign push_acc = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_comb begin
    ovf_d    = clr ? 1'b0 : (ovf_q | drop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (push_acc && !pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!push_acc && pop) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SYNC;
      prev_q   <= 4'h0;
      wrap_q   <= '0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      wrap_q   <= wrap_d;
      ovf_q    <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_acc) begin
      mem_q[wr_ptr_q] <= ev_word;
    end
  end

endmodule

// File: tb/tb_down_count_tracker.sv
// Directed bench for down_count_tracker (DEPTH=4, WRAP_W=8); JUMP expectations follow DCT_JUMP_EVENT_EN.
module tb_down_count_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cnt_in;
  logic        clr;
  logic        ev_valid;
  logic        ev_ready;
  logic [13:0] ev_data;
  logic [7:0]  wrap_cnt;
  logic        ovf;
  logic        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  down_count_tracker #(.DEPTH(4), .WRAP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_in    (cnt_in),
    .clr       (clr),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_data   (ev_data),
    .wrap_cnt  (wrap_cnt),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] ev(input logic [1:0] t, input logic [7:0] w, input logic [3:0] c);
    return {t, w, c};
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic tick(input logic [3:0] c);
    cnt_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] c);
    reset    = 1'b0;
    cnt_in   = c;
    clr      = 1'b0;
    ev_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // From prev == 0: sample F (a wrap), then count E..0.
  task automatic do_wrap();
    tick(4'hF);
    for (int i = 14; i >= 0; i--) tick(4'(i));
  endtask

  task automatic drain(input string tag);
    logic [13:0] e;
    ev_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_valid"}, 32'(ev_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(ev_data), 32'(e));
      tick(cnt_in);
    end
    check_eq({tag, "_empty"}, 32'(ev_valid), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    cnt_in   = 4'h0;
    clr      = 1'b0;
    ev_ready = 1'b0;
    #2;
    check_eq("rst_valid", 32'(ev_valid), 32'd0);
    check_eq("rst_data", 32'(ev_data), 32'd0);
    check_eq("rst_wrap", 32'(wrap_cnt), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // Single wrap: F,E,...,0,F
    do_reset(4'hF);
    for (int i = 15; i >= 0; i--) tick(4'(i));
    check_eq("wrap1_pre_valid", 32'(ev_valid), 32'd0);
    check_eq("wrap1_state", 32'(dbg_state), 32'd1);
    tick(4'hF);
    check_eq("wrap1_valid", 32'(ev_valid), 32'd1);
    check_eq("wrap1_data", 32'(ev_data), 32'(ev(2'b01, 8'd1, 4'hF)));
    check_eq("wrap1_cnt", 32'(wrap_cnt), 32'd1);
    ev_ready = 1'b1;
    tick(4'hE);
    check_eq("wrap1_popped", 32'(ev_valid), 32'd0);

    // Hold then step: no events
    do_reset(4'h7);
    for (int i = 0; i < 11; i++) begin
      tick(4'h7);
      check_eq("hold_valid", 32'(ev_valid), 32'd0);
    end
    tick(4'h6);
    check_eq("step_valid", 32'(ev_valid), 32'd0);

    // Jump 9 -> 3
    do_reset(4'h9);
    tick(4'h9);
    tick(4'h3);
`ifdef DCT_JUMP_EVENT_EN
    check_eq("jump_valid", 32'(ev_valid), 32'd1);
    check_eq("jump_data", 32'(ev_data), 32'(ev(2'b10, 8'd0, 4'h3)));
`else
    check_eq("jump_valid", 32'(ev_valid), 32'd0);
`endif
    check_eq("jump_wrap", 32'(wrap_cnt), 32'd0);

    // Overflow: 5 wraps into a 4-deep FIFO with no consumer
    do_reset(4'h0);
    tick(4'h0);
    for (int k = 1; k <= 5; k++) do_wrap();
    check_eq("ovf_flag", 32'(ovf), 32'd1);
    check_eq("ovf_wrap", 32'(wrap_cnt), 32'd5);
    check_eq("ovf_head_stable", 32'(ev_data), 32'(ev(2'b01, 8'd1, 4'hF)));
    for (int k = 1; k <= 4; k++) exp_q.push_back(ev(2'b01, 8'(k), 4'hF));
    drain("ovf_drain");
    check_eq("ovf_sticky", 32'(ovf), 32'd1);

    // Full FIFO, simultaneous pop and push
    do_reset(4'h0);
    tick(4'h0);
    for (int k = 1; k <= 4; k++) do_wrap();
    check_eq("full_ovf_pre", 32'(ovf), 32'd0);
    ev_ready = 1'b1;
    tick(4'hF);
    check_eq("full_ovf_post", 32'(ovf), 32'd0);
    check_eq("full_wrap", 32'(wrap_cnt), 32'd5);
    for (int k = 2; k <= 5; k++) exp_q.push_back(ev(2'b01, 8'(k), 4'hF));
    drain("full_drain");

    // clr in the same cycle as a wrap
    do_reset(4'h0);
    tick(4'h0);
    do_wrap();
    check_eq("clr_pre_wrap", 32'(wrap_cnt), 32'd1);
    clr = 1'b1;
    tick(4'hF);
    clr = 1'b0;
    check_eq("clr_wrap", 32'(wrap_cnt), 32'd0);
    check_eq("clr_ovf", 32'(ovf), 32'd0);
    exp_q.push_back(ev(2'b01, 8'd1, 4'hF));
    exp_q.push_back(ev(2'b01, 8'd0, 4'hF));
    drain("clr_drain");

    // 256 wraps roll the counter over, then async reset mid-queue
    do_reset(4'h0);
    ev_ready = 1'b1;
    tick(4'h0);
    for (int k = 0; k < 256; k++) do_wrap();
    check_eq("roll_wrap", 32'(wrap_cnt), 32'd0);
    check_eq("roll_ovf", 32'(ovf), 32'd0);
    check_eq("roll_valid", 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;
    do_wrap();
    do_wrap();
    check_eq("mid_valid", 32'(ev_valid), 32'd1);
    check_eq("mid_wrap", 32'(wrap_cnt), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_valid", 32'(ev_valid), 32'd0);
    check_eq("async_wrap", 32'(wrap_cnt), 32'd0);
    check_eq("async_data", 32'(ev_data), 32'd0);
    check_eq("async_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(4'hF);
    check_eq("sync_first_valid", 32'(ev_valid), 32'd0);
    check_eq("sync_first_wrap", 32'(wrap_cnt), 32'd0);
    tick(4'hE);
    check_eq("sync_track_valid", 32'(ev_valid), 32'd0);
    check_eq("sync_track_state", 32'(dbg_state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
